hdmi_aux_scheduler: RTL and testbench

// Downstream consumer of the aux packet buffers (clock regen, audio sample, infoframes).
// On each packet_go, picks one ready source and sweeps aux_slot 0..31 with ae and that source's enable.
// Re-times the returned header/subpacket bits and overwrites the BCH ECC slots.

---
 rtl/hdmi_aux_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_hdmi_aux_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_aux_scheduler.sv
// hdmi_aux_scheduler
// Pulls one aux packet per packet_go from the highest-priority ready source by
// sweeping aux_slot 0..31, re-times the returned bits through two pipeline
// stages, and overwrites the BCH ECC slots so the stream is TERC4-ready.
// With no source ready a null (all-zero) packet is sent.
// Optional feature: define AUX_ROUND_ROBIN_EN for rotating source priority;
// left undefined, source 0 always has the highest priority.
module hdmi_aux_scheduler #(
    parameter int NUM_SRC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 packet_go,
    input  logic [NUM_SRC-1:0]   src_ready,
    input  logic [NUM_SRC-1:0]   src_header,
    input  logic [2*NUM_SRC-1:0] src_sub0,
    input  logic [2*NUM_SRC-1:0] src_sub1,
    input  logic [2*NUM_SRC-1:0] src_sub2,
    input  logic [2*NUM_SRC-1:0] src_sub3,
    output logic [4:0]           aux_slot,
    output logic                 ae,
    output logic [NUM_SRC-1:0]   src_enable,
    output logic                 busy,
    output logic                 out_valid,
    output logic                 out_first,
    output logic [4:0]           out_slot,
    output logic                 out_header,
    output logic [1:0]           out_sub0,
    output logic [1:0]           out_sub1,
    output logic [1:0]           out_sub2,
    output logic [1:0]           out_sub3
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [4:0]           slot_d;
    logic [NUM_SRC-1:0]   enable_d;
    logic [NUM_SRC-1:0]   grant;
    logic                 found;

    logic [2*NUM_SRC-1:0] sub_in [4];

    // stage 1: control re-timed to line up with the source response
    logic                 vld_p1;
    logic [4:0]           slot_p1;
    logic [NUM_SRC-1:0]   en_p1;
    logic                 hdr_p1;
    logic [1:0]           sub_p1 [4];

    // stage 2: ECC accumulators and next output data
    logic [7:0]           ecc_h;
    logic [7:0]           ecc_h_d;
    logic [7:0]           ecc_s   [4];
    logic [7:0]           ecc_s_d [4];
    logic                 hdr_d;
    logic [1:0]           sub_d   [4];
    logic [1:0]           out_sub [4];

`ifdef AUX_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_next;
`endif

    // One LSB-first step of the BCH(1+x^6+x^7+x^8) parity register.
    function automatic logic [7:0] bch_step(input logic [7:0] p, input logic b);
        logic f;
        f = b ^ p[0];
        return (p >> 1) ^ (f ? 8'h83 : 8'h00);
    endfunction

    assign sub_in[0] = src_sub0;
    assign sub_in[1] = src_sub1;
    assign sub_in[2] = src_sub2;
    assign sub_in[3] = src_sub3;

    assign out_sub0  = out_sub[0];
    assign out_sub1  = out_sub[1];
    assign out_sub2  = out_sub[2];
    assign out_sub3  = out_sub[3];

    assign ae   = (state_q == SEND);
    assign busy = (state_q == SEND);

    // Pick the first ready source, searching from the priority start point.
    always_comb begin
        grant = '0;
        found = 1'b0;
`ifdef AUX_ROUND_ROBIN_EN
        rr_next = rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!found && src_ready[j] && (j == (int'(rr_ptr) + k) % NUM_SRC)) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    rr_next  = PTR_W'((j + 1) % NUM_SRC);
                end
            end
        end
`else
        for (int j = 0; j < NUM_SRC; j++) begin
            if (!found && src_ready[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
            end
        end
`endif
    end

    // Next state: start or chain a sweep on packet_go, otherwise count slots.
    always_comb begin
        state_d  = state_q;
        slot_d   = aux_slot;
        enable_d = src_enable;
        case (state_q)
            IDLE: begin
                if (packet_go) begin
                    state_d  = SEND;
                    slot_d   = 5'd0;
                    enable_d = grant;
                end
            end
            SEND: begin
                if (aux_slot == 5'd31) begin
                    if (packet_go) begin
                        slot_d   = 5'd0;
                        enable_d = grant;
                    end else begin
                        state_d  = IDLE;
                        slot_d   = 5'd0;
                        enable_d = '0;
                    end
                end else begin
                    slot_d = aux_slot + 5'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                slot_d   = 5'd0;
                enable_d = '0;
            end
        endcase
    end

    // Sweep state register; reset aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            aux_slot   <= 5'd0;
            src_enable <= '0;
        end else begin
            state_q    <= state_d;
            aux_slot   <= slot_d;
            src_enable <= enable_d;
        end
    end

`ifdef AUX_ROUND_ROBIN_EN
    // Advance the rotating priority past each source that wins a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state_d == SEND && slot_d == 5'd0 && found) begin
            rr_ptr <= rr_next;
        end
    end
`endif

    // Stage 1: delay slot/valid/enable by the source's one-cycle response time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            slot_p1 <= 5'd0;
            en_p1   <= '0;
        end else begin
            vld_p1  <= ae;
            slot_p1 <= aux_slot;
            en_p1   <= src_enable;
        end
    end

    // Stage 1 data: mux the enabled source's bits; null packets read as zero.
    always_comb begin
        hdr_p1 = |(src_header & en_p1);
        for (int m = 0; m < 4; m++) begin
            sub_p1[m] = 2'b00;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (en_p1[i]) begin
                    sub_p1[m] = sub_p1[m] | sub_in[m][2*i +: 2];
                end
            end
        end
    end

    // ECC: accumulate over the data slots, then replace the parity slots.
    always_comb begin
        ecc_h_d = (slot_p1 == 5'd0) ? 8'h00 : ecc_h;
        hdr_d   = 1'b0;
        if (slot_p1 < 5'd24) begin
            hdr_d   = hdr_p1;
            ecc_h_d = bch_step(ecc_h_d, hdr_p1);
        end else begin
            hdr_d = ecc_h_d[slot_p1[2:0]];
        end
        for (int m = 0; m < 4; m++) begin
            ecc_s_d[m] = (slot_p1 == 5'd0) ? 8'h00 : ecc_s[m];
            sub_d[m]   = 2'b00;
            if (slot_p1 < 5'd28) begin
                sub_d[m]   = sub_p1[m];
                ecc_s_d[m] = bch_step(bch_step(ecc_s_d[m], sub_p1[m][0]), sub_p1[m][1]);
            end else begin
                sub_d[m] = ecc_s_d[m][{slot_p1[1:0], 1'b0} +: 2];
            end
        end
    end

    // Stage 2: register the ECC-inserted packet stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_slot   <= 5'd0;
            out_header <= 1'b0;
            ecc_h      <= 8'h00;
            for (int m = 0; m < 4; m++) begin
                out_sub[m] <= 2'b00;
                ecc_s[m]   <= 8'h00;
            end
        end else begin
            out_valid <= vld_p1;
            out_first <= vld_p1 && (slot_p1 == 5'd0);
            out_slot  <= slot_p1;
            if (vld_p1) begin
                out_header <= hdr_d;
                ecc_h      <= ecc_h_d;
                for (int m = 0; m < 4; m++) begin
                    out_sub[m] <= sub_d[m];
                    ecc_s[m]   <= ecc_s_d[m];
                end
            end else begin
                out_header <= 1'b0;
                for (int m = 0; m < 4; m++) begin
                    out_sub[m] <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_aux_scheduler.sv
// Testbench for hdmi_aux_scheduler: packet-level reference model feeding a
// scoreboard queue, with an independent output monitor.
module tb_hdmi_aux_scheduler;

    localparam int NS = 2;
`ifdef AUX_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       packet_go = 1'b0;
    logic [1:0] src_ready = 2'b00;
    logic [1:0] src_header = 2'b00;
    logic [3:0] src_sub0 = 4'h0;
    logic [3:0] src_sub1 = 4'h0;
    logic [3:0] src_sub2 = 4'h0;
    logic [3:0] src_sub3 = 4'h0;
    logic [4:0] aux_slot;
    logic       ae;
    logic [1:0] src_enable;
    logic       busy;
    logic       out_valid;
    logic       out_first;
    logic [4:0] out_slot;
    logic       out_header;
    logic [1:0] out_sub0, out_sub1, out_sub2, out_sub3;

    always #5 clk = ~clk;

    hdmi_aux_scheduler #(.NUM_SRC(NS)) dut (
        .clk(clk), .rst_n(rst_n), .packet_go(packet_go),
        .src_ready(src_ready), .src_header(src_header),
        .src_sub0(src_sub0), .src_sub1(src_sub1), .src_sub2(src_sub2), .src_sub3(src_sub3),
        .aux_slot(aux_slot), .ae(ae), .src_enable(src_enable), .busy(busy),
        .out_valid(out_valid), .out_first(out_first), .out_slot(out_slot),
        .out_header(out_header),
        .out_sub0(out_sub0), .out_sub1(out_sub1), .out_sub2(out_sub2), .out_sub3(out_sub3)
    );

    typedef struct packed {
        logic [4:0]      slot;
        logic            first;
        logic            hdr;
        logic [3:0][1:0] sub;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] cur_hdr [NS];
    logic [63:0] cur_sub [NS][4];

    // packet-level model state
    bit          m_busy = 1'b0;
    int          m_slot = 0;
    logic [1:0]  m_en = 2'b00;
    int          rr = 0;
    int          n_acc = 0;

    int          ae_cnt = 0;
    int          first_cnt = 0;
    int          run = 0;
    int          last_run = 0;
    logic [7:0]  hdr_ecc_seen = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
        logic [7:0] p;
        logic       f;
        p = 8'h00;
        for (int i = 0; i < n; i++) begin
            f = bits[i] ^ p[0];
            p = (p >> 1) ^ (f ? 8'h83 : 8'h00);
        end
        return p;
    endfunction

    function automatic int pick(input logic [1:0] rdy, input int start);
        for (int k = 0; k < NS; k++) begin
            if (rdy[(start + k) % NS]) return (start + k) % NS;
        end
        return -1;
    endfunction

    // Expected 32-slot packet for source g (g < 0: null packet).
    task automatic push_packet(input int g);
        logic [31:0] h;
        logic [63:0] s [4];
        logic [7:0]  ph;
        logic [7:0]  ps [4];
        exp_t        e;
        h = 32'h0;
        for (int m = 0; m < 4; m++) s[m] = 64'h0;
        if (g >= 0) begin
            h = cur_hdr[g];
            for (int m = 0; m < 4; m++) s[m] = cur_sub[g][m];
        end
        ph = bch({40'h0, h[23:0]}, 24);
        for (int m = 0; m < 4; m++) ps[m] = bch(s[m], 56);
        for (int sl = 0; sl < 32; sl++) begin
            e.slot  = 5'(sl);
            e.first = (sl == 0);
            e.hdr   = (sl < 24) ? h[sl] : ph[sl-24];
            for (int m = 0; m < 4; m++)
                e.sub[m] = (sl < 28) ? s[m][2*sl +: 2] : ps[m][2*(sl-28) +: 2];
            sbq.push_back(e);
        end
    endtask

    task automatic load(input int i);
        cur_hdr[i] = $urandom;
        for (int m = 0; m < 4; m++) cur_sub[i][m] = {$urandom, $urandom};
    endtask

    // One clock: advance the model, check sweep control, play the sources.
    task automatic tick();
        logic [4:0] req_slot;
        logic [1:0] req_act;
        logic       go, rn;
        logic [1:0] rdy;
        int         g;
        req_slot = aux_slot;
        req_act  = ae ? src_enable : 2'b00;
        go       = packet_go;
        rn       = rst_n;
        rdy      = src_ready;
        @(posedge clk);
        #1;
        if (!rn) begin
            m_busy = 1'b0; m_slot = 0; m_en = 2'b00; rr = 0;
            sbq.delete();
        end else if (go && (!m_busy || m_slot == 31)) begin
            g = pick(rdy, RR ? rr : 0);
            m_busy = 1'b1;
            m_slot = 0;
            m_en   = (g < 0) ? 2'b00 : 2'(1 << g);
            if (RR && g >= 0) rr = (g + 1) % NS;
            push_packet(g);
            n_acc++;
        end else if (m_busy) begin
            if (m_slot == 31) begin
                m_busy = 1'b0; m_slot = 0; m_en = 2'b00;
            end else begin
                m_slot++;
            end
        end
        check("aux_slot", 32'(aux_slot), 32'(m_slot));
        check("ae", 32'(ae), 32'(m_busy));
        check("busy", 32'(busy), 32'(m_busy));
        check("src_enable", 32'(src_enable), 32'(m_en));
        if (ae) ae_cnt++;
        for (int i = 0; i < NS; i++) begin
            src_header[i]       = cur_hdr[i][req_slot];
            src_sub0[2*i +: 2]  = cur_sub[i][0][2*req_slot +: 2];
            src_sub1[2*i +: 2]  = cur_sub[i][1][2*req_slot +: 2];
            src_sub2[2*i +: 2]  = cur_sub[i][2][2*req_slot +: 2];
            src_sub3[2*i +: 2]  = cur_sub[i][3][2*req_slot +: 2];
        end
        src_ready = src_ready & ~req_act;
    endtask

    task automatic wait_slot(input int s);
        int guard;
        guard = 0;
        while (!(m_busy && m_slot == s) && guard < 100) begin
            tick();
            guard++;
        end
        check("wait_slot_reached", 32'(m_busy && m_slot == s), 32'd1);
    endtask

    // Output monitor: every valid slot must match the head of the scoreboard.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            run++;
            if (out_first) first_cnt++;
            if (out_slot >= 5'd24) hdr_ecc_seen[out_slot[2:0]] = out_header;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out slot=%0d required=no_output", out_slot);
            end else begin
                mon_e = sbq.pop_front();
                check("out_slot", 32'(out_slot), 32'(mon_e.slot));
                check("out_first", 32'(out_first), 32'(mon_e.first));
                check("out_header", 32'(out_header), 32'(mon_e.hdr));
                check("out_sub0", 32'(out_sub0), 32'(mon_e.sub[0]));
                check("out_sub1", 32'(out_sub1), 32'(mon_e.sub[1]));
                check("out_sub2", 32'(out_sub2), 32'(mon_e.sub[2]));
                check("out_sub3", 32'(out_sub3), 32'(mon_e.sub[3]));
            end
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < NS; i++) begin
            cur_hdr[i] = 32'h0;
            for (int m = 0; m < 4; m++) cur_sub[i][m] = 64'h0;
        end

        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_aux_slot", 32'(aux_slot), 32'd0);
        check("rst_ae", 32'(ae), 32'd0);
        check("rst_src_enable", 32'(src_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_first", 32'(out_first), 32'd0);
        check("rst_out_slot", 32'(out_slot), 32'd0);
        check("rst_out_data", 32'({out_header, out_sub0, out_sub1, out_sub2, out_sub3}), 32'd0);
        rst_n = 1'b1;
        tick();

        // null packet
        ae_cnt = 0; first_cnt = 0;
        packet_go = 1'b1; tick(); packet_go = 1'b0;
        repeat (40) tick();
        check("null_ae_cycles", 32'(ae_cnt), 32'd32);
        check("null_first_count", 32'(first_cnt), 32'd1);

        // known header 0x000001 from source 0
        cur_hdr[0] = 32'h0000_0001;
        for (int m = 0; m < 4; m++) cur_sub[0][m] = 64'h0;
        src_ready = 2'b01;
        hdr_ecc_seen = 8'h00;
        packet_go = 1'b1; tick(); packet_go = 1'b0;
        repeat (40) tick();
        check("hdr_ecc_known", 32'(hdr_ecc_seen), 32'h4A);

        // both ready, back-to-back sweeps
        load(0); load(1);
        src_ready = 2'b11;
        last_run = 0;
        packet_go = 1'b1; tick(); packet_go = 1'b0;
        check("b2b_first_grant", 32'(src_enable), 32'h1);
        wait_slot(31);
        packet_go = 1'b1; tick(); packet_go = 1'b0;
        check("b2b_second_grant", 32'(src_enable), 32'h2);
        repeat (40) tick();
        check("b2b_contiguous_valid", 32'(last_run), 32'd64);

        // third sweep with both ready
        load(0); load(1);
        src_ready = 2'b11;
        packet_go = 1'b1; tick(); packet_go = 1'b0;
        check("third_grant", 32'(src_enable), 32'h1);
        repeat (40) tick();
        src_ready = 2'b00;
        repeat (40) tick();

        // packet_go mid-sweep is ignored
        ae_cnt = 0;
        packet_go = 1'b1; tick(); packet_go = 1'b0;
        wait_slot(10);
        packet_go = 1'b1; tick(); packet_go = 1'b0;
        repeat (40) tick();
        check("ignored_go_ae_cycles", 32'(ae_cnt), 32'd32);
        check("ignored_go_busy_low", 32'(busy), 32'd0);

        // reset mid-sweep
        load(0);
        src_ready = 2'b01;
        packet_go = 1'b1; tick(); packet_go = 1'b0;
        wait_slot(15);
        rst_n = 1'b0; tick();
        check("midrst_ae", 32'(ae), 32'd0);
        check("midrst_src_enable", 32'(src_enable), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_aux_slot", 32'(aux_slot), 32'd0);
        rst_n = 1'b1;
        repeat (10) tick();

        // randomized traffic
        n_acc = 0;
        guard = 0;
        while (n_acc < 200 && guard < 30000) begin
            for (int i = 0; i < NS; i++) begin
                if (!src_ready[i] && !(m_busy && m_en[i]) && $urandom_range(0, 3) == 0) begin
                    load(i);
                    src_ready[i] = 1'b1;
                end
            end
            packet_go = ($urandom_range(0, 5) == 0);
            tick();
            guard++;
        end
        packet_go = 1'b0;
        repeat (40) tick();
        check("random_packets_done", 32'(n_acc >= 200), 32'd1);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
